// File: rtl/bsg_manycore_tag_packet_tx.sv
// Serial bsg_tag packet transmitter: one packet per valid/ready handshake, shifted out MSB-first on tag_data_o.
// Frame = start bit | node_id | data_not_reset | len | payload[len-1:0], followed by gap_p zero bits.
module bsg_manycore_tag_packet_tx #(
  parameter  int num_clients_p       = 32,
  parameter  int max_payload_width_p = 15,
  parameter  int bit_period_p        = 1,
  parameter  int gap_p               = 2,
  parameter  int init_zeros_p        = 8,
  localparam int lg_els_lp           = $clog2(num_clients_p),
  localparam int lg_width_lp         = $clog2(max_payload_width_p+1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  input  logic [lg_els_lp-1:0]           node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_lp-1:0]         len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           ready_o,
  output logic                           tag_data_o,
  output logic                           busy_o
);

  localparam int per_w_lp   = $clog2(bit_period_p+1);
  localparam int max_a_lp   = (lg_els_lp > lg_width_lp) ? lg_els_lp : lg_width_lp;
  localparam int max_b_lp   = (max_a_lp > max_payload_width_p) ? max_a_lp : max_payload_width_p;
  localparam int max_c_lp   = (max_b_lp > gap_p) ? max_b_lp : gap_p;
  localparam int cnt_max_lp = (max_c_lp > init_zeros_p) ? max_c_lp : init_zeros_p;
  localparam int cnt_w_lp   = $clog2(cnt_max_lp+1);

  typedef logic [per_w_lp-1:0] per_t;
  typedef logic [cnt_w_lp-1:0] cnt_t;

  localparam per_t per_reload_lp = per_t'(bit_period_p-1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_START, S_NODE, S_DNR, S_LEN, S_PAYLOAD, S_GAP
  } state_e;

  state_e                         state_q, state_d;
  per_t                           per_q, per_d;
  cnt_t                           bit_q, bit_d;
  logic [lg_els_lp-1:0]           node_q, node_d;
  logic                           dnr_q, dnr_d;
  logic [lg_width_lp-1:0]         len_q, len_d;
  logic [max_payload_width_p-1:0] pay_q, pay_d;
  logic                           tag_q, tag_d;
  logic [lg_els_lp-1:0]           node_sh;
  logic [lg_width_lp-1:0]         len_sh;
  logic [max_payload_width_p-1:0] pay_sh;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    bit_d   = bit_q;
    node_d  = node_q;
    dnr_d   = dnr_q;
    len_d   = len_q;
    pay_d   = pay_q;
    tag_d   = 1'b0;
    node_sh = '0;
    len_sh  = '0;
    pay_sh  = '0;

    if (state_q == S_IDLE) begin
      if (v_i) begin
        state_d = S_START;
        per_d   = per_reload_lp;
        bit_d   = '0;
        node_d  = node_id_i;
        dnr_d   = data_not_reset_i;
        len_d   = len_i;
        pay_d   = payload_i;
      end
    end else if (per_q != '0) begin
      per_d = per_q - per_t'(1);
    end else begin
      per_d = per_reload_lp;
      if (bit_q != '0) begin
        bit_d = bit_q - cnt_t'(1);
      end else begin
        // Last bit of the current field: load the next field's MSB index.
        case (state_q)
          S_START: begin state_d = S_NODE; bit_d = cnt_t'(lg_els_lp-1);   end
          S_NODE:  begin state_d = S_DNR;  bit_d = '0;                     end
          S_DNR:   begin state_d = S_LEN;  bit_d = cnt_t'(lg_width_lp-1); end
          S_LEN: begin
            if (len_q != '0) begin
              state_d = S_PAYLOAD;
              bit_d   = cnt_t'(len_q) - cnt_t'(1);
            end else begin
              state_d = S_GAP;
              bit_d   = cnt_t'(gap_p-1);
            end
          end
          S_PAYLOAD: begin state_d = S_GAP; bit_d = cnt_t'(gap_p-1); end
          default:   state_d = S_IDLE;
        endcase
      end
    end

    // The output flop holds the bit belonging to the next state/index.
    node_sh = node_d >> bit_d;
    len_sh  = len_d >> bit_d;
    pay_sh  = pay_d >> bit_d;
    case (state_d)
      S_START:   tag_d = 1'b1;
      S_NODE:    tag_d = node_sh[0];
      S_DNR:     tag_d = dnr_d;
      S_LEN:     tag_d = len_sh[0];
      S_PAYLOAD: tag_d = pay_sh[0];
      default:   tag_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_INIT;
      per_q   <= per_reload_lp;
      bit_q   <= cnt_t'(init_zeros_p-1);
      node_q  <= '0;
      dnr_q   <= 1'b0;
      len_q   <= '0;
      pay_q   <= '0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      node_q  <= node_d;
      dnr_q   <= dnr_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && v_i && state_q == S_IDLE)
      assert (int'(len_i) <= max_payload_width_p);
  end

  assign ready_o    = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign tag_data_o = tag_q;

endmodule
